// File: rtl/vga_wr_arbiter_if.sv
// CPU memory-mapped write bus into the VGA write arbiter.
// The CPU side drives a single-cycle request; the arbiter answers with ack/err one cycle later.
interface vga_wr_arbiter_if;
  logic        cpu_req;
  logic        cpu_sel;
  logic [18:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_ack;
  logic        cpu_err;

  modport master (
    output cpu_req, cpu_sel, cpu_addr, cpu_data,
    input  cpu_ack, cpu_err
  );

  modport slave (
    input  cpu_req, cpu_sel, cpu_addr, cpu_data,
    output cpu_ack, cpu_err
  );
endinterface

// File: rtl/vga_wr_arbiter.sv
// VGA write arbiter: sole writer of the text and graph video memories.
// The CPU path has fixed priority on each port. The fill engine writes one cell or pixel
// per cycle in which it is granted. The fill engine also stalls when the CPU takes its port.
// All outputs are registered. A CPU request in cycle N shows up on the ports in cycle N+1.
module vga_wr_arbiter #(
  parameter int TEXT_DEPTH  = 2400,
  parameter int GRAPH_DEPTH = 307200
) (
  input  logic               i_clk,
  input  logic               i_rst,
  vga_wr_arbiter_if.slave    cpu_bus,
  input  logic               i_mode_we,
  input  logic               i_mode,
  input  logic               i_clr_start,
  input  logic [1:0]         i_clr_target,
  input  logic [15:0]        i_clr_char,
  input  logic [3:0]         i_clr_px,
  output logic               o_clr_busy,
  output logic               o_clr_done,
  output logic [15:0]        o_vga_char,
  output logic [11:0]        o_vga_char_addr,
  output logic               o_vga_char_we,
  output logic [3:0]         o_graph_px,
  output logic [18:0]        o_graph_addr,
  output logic               o_graph_we,
  output logic               o_draw_mode_sel
);

  localparam logic [18:0] TEXT_LIM   = 19'(TEXT_DEPTH);
  localparam logic [18:0] GRAPH_LIM  = 19'(GRAPH_DEPTH);
  localparam logic [18:0] TEXT_LAST  = 19'(TEXT_DEPTH - 1);
  localparam logic [18:0] GRAPH_LAST = 19'(GRAPH_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLR_TEXT  = 2'd1,
    ST_CLR_GRAPH = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [18:0] r_cnt;
  logic [18:0] w_cnt_next;

  // Fill parameters captured at start so the engine is immune to later input changes.
  logic [1:0]  r_target;
  logic [15:0] r_clr_char;
  logic [3:0]  r_clr_px;

  // Output registers
  logic        r_ack;
  logic        r_err;
  logic        r_char_we;
  logic [11:0] r_char_addr;
  logic [15:0] r_char;
  logic        r_graph_we;
  logic [18:0] r_graph_addr;
  logic [3:0]  r_graph_px;
  logic        r_busy;
  logic        r_done;
  logic        r_mode;

  // Decoded CPU request and per-port grant
  logic        w_cpu_text_ok;
  logic        w_cpu_graph_ok;
  logic        w_cpu_err;
  logic        w_eng_text_grant;
  logic        w_eng_graph_grant;
  logic        w_start;

  // Next-cycle values of the write ports
  logic        w_char_we;
  logic [11:0] w_char_addr;
  logic [15:0] w_char;
  logic        w_graph_we;
  logic [18:0] w_graph_addr;
  logic [3:0]  w_graph_px;

  // Decode the CPU request, check its address range and work out where the engine is granted.
  always_comb begin
    w_cpu_text_ok     = cpu_bus.cpu_req & ~cpu_bus.cpu_sel & (cpu_bus.cpu_addr < TEXT_LIM);
    w_cpu_graph_ok    = cpu_bus.cpu_req &  cpu_bus.cpu_sel & (cpu_bus.cpu_addr < GRAPH_LIM);
    w_cpu_err         = cpu_bus.cpu_req & ~(w_cpu_text_ok | w_cpu_graph_ok);
    w_eng_text_grant  = (r_state == ST_CLR_TEXT)  & ~w_cpu_text_ok;
    w_eng_graph_grant = (r_state == ST_CLR_GRAPH) & ~w_cpu_graph_ok;
    w_start           = (r_state == ST_IDLE) & i_clr_start;
  end

  // Drive the write ports. The CPU goes first, and otherwise the engine writes its current counter.
  always_comb begin
    w_char_we    = w_cpu_text_ok | w_eng_text_grant;
    w_graph_we   = w_cpu_graph_ok | w_eng_graph_grant;
    if (w_cpu_text_ok) begin
      w_char_addr = cpu_bus.cpu_addr[11:0];
      w_char      = cpu_bus.cpu_data;
    end else begin
      w_char_addr = r_cnt[11:0];
      w_char      = r_clr_char;
    end
    if (w_cpu_graph_ok) begin
      w_graph_addr = cpu_bus.cpu_addr;
      w_graph_px   = cpu_bus.cpu_data[3:0];
    end else begin
      w_graph_addr = r_cnt;
      w_graph_px   = r_clr_px;
    end
  end

  // Fill FSM next state and counter. The counter advances only on a granted write and clears on state entry.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = 19'd0;
        if (i_clr_start) begin
          if (i_clr_target[0]) begin
            w_state_next = ST_CLR_TEXT;
          end else if (i_clr_target[1]) begin
            w_state_next = ST_CLR_GRAPH;
          end else begin
            w_state_next = ST_DONE;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CLR_TEXT: begin
        if (w_eng_text_grant) begin
          if (r_cnt == TEXT_LAST) begin
            w_cnt_next   = 19'd0;
            w_state_next = r_target[1] ? ST_CLR_GRAPH : ST_DONE;
          end else begin
            w_cnt_next = r_cnt + 19'd1;
          end
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      ST_CLR_GRAPH: begin
        if (w_eng_graph_grant) begin
          if (r_cnt == GRAPH_LAST) begin
            w_cnt_next   = 19'd0;
            w_state_next = ST_DONE;
          end else begin
            w_cnt_next = r_cnt + 19'd1;
          end
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      ST_DONE: begin
        w_cnt_next   = 19'd0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_cnt_next   = 19'd0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter and captured fill parameters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 19'd0;
      r_target   <= 2'd0;
      r_clr_char <= 16'd0;
      r_clr_px   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_start) begin
        r_target   <= i_clr_target;
        r_clr_char <= i_clr_char;
        r_clr_px   <= i_clr_px;
      end
    end
  end

  // Register every output. Busy covers the cycle after start through the done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_char_we    <= 1'b0;
      r_char_addr  <= 12'd0;
      r_char       <= 16'd0;
      r_graph_we   <= 1'b0;
      r_graph_addr <= 19'd0;
      r_graph_px   <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mode       <= 1'b0;
    end else begin
      r_ack        <= cpu_bus.cpu_req;
      r_err        <= w_cpu_err;
      r_char_we    <= w_char_we;
      r_char_addr  <= w_char_addr;
      r_char       <= w_char;
      r_graph_we   <= w_graph_we;
      r_graph_addr <= w_graph_addr;
      r_graph_px   <= w_graph_px;
      r_busy       <= (w_state_next != ST_IDLE) | (r_state != ST_IDLE);
      r_done       <= (r_state == ST_DONE);
      if (i_mode_we) begin
        r_mode <= i_mode;
      end
    end
  end

  assign cpu_bus.cpu_ack = r_ack;
  assign cpu_bus.cpu_err = r_err;
  assign o_vga_char_we   = r_char_we;
  assign o_vga_char_addr = r_char_addr;
  assign o_vga_char      = r_char;
  assign o_graph_we      = r_graph_we;
  assign o_graph_addr    = r_graph_addr;
  assign o_graph_px      = r_graph_px;
  assign o_clr_busy      = r_busy;
  assign o_clr_done      = r_done;
  assign o_draw_mode_sel = r_mode;

endmodule
